// File: rtl/apb_2_lint.sv
// APB slave to LINT master bridge: one APB access becomes exactly one LINT request/response.
// Optional grant timeout is compiled in with `define APB_2_LINT_GNT_TIMEOUT_EN.
module apb_2_lint #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = DATA_WIDTH / 8,
    parameter int ID_WIDTH    = 10,
    parameter int AUX_WIDTH   = 8,
    parameter int ID_VALUE    = 0,
    parameter int GNT_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,

    input  logic [ADDR_WIDTH-1:0] slave_PADDR,
    input  logic [DATA_WIDTH-1:0] slave_PWDATA,
    input  logic                  slave_PWRITE,
    input  logic                  slave_PSEL,
    input  logic                  slave_PENABLE,
    output logic [DATA_WIDTH-1:0] slave_PRDATA,
    output logic                  slave_PREADY,
    output logic                  slave_PSLVERR,

    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_add_o,
    output logic                  data_wen_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    output logic [AUX_WIDTH-1:0]  data_aux_o,
    output logic [ID_WIDTH-1:0]   data_ID_o,
    input  logic                  data_gnt_i,

    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic                  data_r_opc_i,
    input  logic [AUX_WIDTH-1:0]  data_r_aux_i,
    input  logic [ID_WIDTH-1:0]   data_r_ID_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_RVALID,
        RESP
    } state_t;

    state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] add_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  opc_q;
    logic                  timeout;
    logic                  apb_access;

    assign apb_access = slave_PSEL && slave_PENABLE;

`ifdef APB_2_LINT_GNT_TIMEOUT_EN
    // Fires on the last allowed ungranted REQ cycle, so req is held exactly GNT_TIMEOUT cycles.
    localparam logic [7:0] TIMEOUT_LAST = 8'(GNT_TIMEOUT - 1);

    logic [7:0] gnt_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_cnt_q <= 8'd0;
        end else if (state_q != REQ) begin
            gnt_cnt_q <= 8'd0;
        end else if (!data_gnt_i) begin
            gnt_cnt_q <= gnt_cnt_q + 8'd1;
        end
    end

    assign timeout = (state_q == REQ) && !data_gnt_i && (gnt_cnt_q == TIMEOUT_LAST);
`else
    logic [7:0] unused_gnt_timeout;
    assign unused_gnt_timeout = 8'(GNT_TIMEOUT);
    assign timeout            = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (apb_access) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (data_gnt_i) begin
                    state_d = WAIT_RVALID;
                end else if (timeout) begin
                    state_d = RESP;
                end
            end
            WAIT_RVALID: begin
                if (data_r_valid_i) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request fields are captured once per access and held until the next access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            add_q   <= '0;
            wdata_q <= '0;
            wen_q   <= 1'b1;
        end else if (state_q == IDLE && apb_access) begin
            add_q   <= slave_PADDR;
            wdata_q <= slave_PWDATA;
            wen_q   <= ~slave_PWRITE;
        end
    end

    // Response fields persist after RESP; a timeout reports an error with zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            opc_q   <= 1'b0;
        end else if (state_q == WAIT_RVALID && data_r_valid_i) begin
            rdata_q <= wen_q ? data_r_rdata_i : '0;
            opc_q   <= data_r_opc_i;
        end else if (state_q == REQ && !data_gnt_i && timeout) begin
            rdata_q <= '0;
            opc_q   <= 1'b1;
        end
    end

    assign data_req_o    = (state_q == REQ);
    assign data_add_o    = add_q;
    assign data_wen_o    = wen_q;
    assign data_wdata_o  = wdata_q;
    assign data_be_o     = '1;
    assign data_aux_o    = '0;
    assign data_ID_o     = ID_WIDTH'(ID_VALUE);

    assign slave_PREADY  = (state_q == RESP);
    assign slave_PRDATA  = rdata_q;
    assign slave_PSLVERR = opc_q;

    logic unused_resp_fields;
    assign unused_resp_fields = ^{data_r_aux_i, data_r_ID_i};

endmodule

// File: tb/tb_apb_2_lint.sv
// Directed bench for apb_2_lint: APB responses are predicted into a queue and checked by a PREADY monitor.
module tb_apb_2_lint;

    logic        clk;
    logic        rst_n;
    logic [31:0] slave_PADDR;
    logic [31:0] slave_PWDATA;
    logic        slave_PWRITE;
    logic        slave_PSEL;
    logic        slave_PENABLE;
    logic [31:0] slave_PRDATA;
    logic        slave_PREADY;
    logic        slave_PSLVERR;
    logic        data_req_o;
    logic [31:0] data_add_o;
    logic        data_wen_o;
    logic [31:0] data_wdata_o;
    logic [3:0]  data_be_o;
    logic [7:0]  data_aux_o;
    logic [9:0]  data_ID_o;
    logic        data_gnt_i;
    logic        data_r_valid_i;
    logic [31:0] data_r_rdata_i;
    logic        data_r_opc_i;
    logic [7:0]  data_r_aux_i;
    logic [9:0]  data_r_ID_i;

    int vectors     = 0;
    int miscompares = 0;

    logic [32:0] exp_q[$];
    logic [32:0] mon_e;

    apb_2_lint #(
        .GNT_TIMEOUT(4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .slave_PADDR   (slave_PADDR),
        .slave_PWDATA  (slave_PWDATA),
        .slave_PWRITE  (slave_PWRITE),
        .slave_PSEL    (slave_PSEL),
        .slave_PENABLE (slave_PENABLE),
        .slave_PRDATA  (slave_PRDATA),
        .slave_PREADY  (slave_PREADY),
        .slave_PSLVERR (slave_PSLVERR),
        .data_req_o    (data_req_o),
        .data_add_o    (data_add_o),
        .data_wen_o    (data_wen_o),
        .data_wdata_o  (data_wdata_o),
        .data_be_o     (data_be_o),
        .data_aux_o    (data_aux_o),
        .data_ID_o     (data_ID_o),
        .data_gnt_i    (data_gnt_i),
        .data_r_valid_i(data_r_valid_i),
        .data_r_rdata_i(data_r_rdata_i),
        .data_r_opc_i  (data_r_opc_i),
        .data_r_aux_i  (data_r_aux_i),
        .data_r_ID_i   (data_r_ID_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Every PREADY pulse must match the oldest predicted response.
    always @(negedge clk) begin
        if (slave_PREADY) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pready", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("prdata", slave_PRDATA, mon_e[32:1]);
                checkOutput("pslverr", {31'd0, slave_PSLVERR}, {31'd0, mon_e[0]});
            end
        end
    end

    task automatic apbSetupAccess(input logic [31:0] addr, input logic [31:0] wdata, input logic write);
        @(posedge clk); #1;
        slave_PSEL    = 1'b1;
        slave_PENABLE = 1'b0;
        slave_PADDR   = addr;
        slave_PWDATA  = wdata;
        slave_PWRITE  = write;
        @(posedge clk); #1;
        slave_PENABLE = 1'b1;
    endtask

    task automatic apbRelease();
        slave_PSEL    = 1'b0;
        slave_PENABLE = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic write,
                                 input int gnt_wait, input int rvalid_wait,
                                 input logic [31:0] rdata, input logic opc, input logic drop_psel,
                                 input logic [31:0] exp_rdata, input logic exp_err);
        int req_cycles;
        apbSetupAccess(addr, wdata, write);
        @(negedge clk);
        checkOutput("req_low_in_access_cycle", {31'd0, data_req_o}, 32'd0);
        exp_q.push_back({exp_rdata, exp_err});
        @(posedge clk); #1;
        checkOutput("data_add", data_add_o, addr);
        checkOutput("data_wen", {31'd0, data_wen_o}, {31'd0, ~write});
        checkOutput("data_wdata", data_wdata_o, wdata);
        checkOutput("data_be", {28'd0, data_be_o}, 32'hF);
        req_cycles = 0;
        for (int i = 0; i <= gnt_wait; i++) begin
            data_gnt_i = (i == gnt_wait);
            @(negedge clk);
            if (data_req_o) req_cycles++;
            @(posedge clk); #1;
        end
        data_gnt_i = 1'b0;
        checkOutput("req_cycles", req_cycles, gnt_wait + 1);
        if (drop_psel) apbRelease();
        @(negedge clk);
        checkOutput("req_low_after_gnt", {31'd0, data_req_o}, 32'd0);
        for (int j = 0; j < rvalid_wait; j++) begin
            @(posedge clk); #1;
        end
        data_r_valid_i = 1'b1;
        data_r_rdata_i = rdata;
        data_r_opc_i   = opc;
        data_r_aux_i   = 8'hA5;
        data_r_ID_i    = 10'h3C3;
        @(posedge clk); #1;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = 32'h0;
        data_r_opc_i   = 1'b0;
        @(negedge clk);
        checkOutput("pready_on_time", {31'd0, slave_PREADY}, 32'd1);
        @(posedge clk); #1;
        apbRelease();
        @(negedge clk);
        checkOutput("pready_single_pulse", {31'd0, slave_PREADY}, 32'd0);
    endtask

    task automatic checkResetState();
        checkOutput("rst_req", {31'd0, data_req_o}, 32'd0);
        checkOutput("rst_pready", {31'd0, slave_PREADY}, 32'd0);
        checkOutput("rst_prdata", slave_PRDATA, 32'd0);
        checkOutput("rst_pslverr", {31'd0, slave_PSLVERR}, 32'd0);
        checkOutput("rst_wen", {31'd0, data_wen_o}, 32'd1);
        checkOutput("rst_add", data_add_o, 32'd0);
        checkOutput("rst_wdata", data_wdata_o, 32'd0);
    endtask

    initial begin
        int req_cycles;
        logic seen_ready;
        rst_n          = 1'b0;
        slave_PADDR    = 32'h0;
        slave_PWDATA   = 32'h0;
        slave_PWRITE   = 1'b0;
        apbRelease();
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = 32'h0;
        data_r_opc_i   = 1'b0;
        data_r_aux_i   = 8'h0;
        data_r_ID_i    = 10'h0;
        repeat (3) @(posedge clk);
        #1;
        checkResetState();
        checkOutput("const_be", {28'd0, data_be_o}, 32'hF);
        checkOutput("const_aux", {24'd0, data_aux_o}, 32'd0);
        checkOutput("const_id", {22'd0, data_ID_o}, 32'd0);
        rst_n = 1'b1;

        $display("[TB] setup-only phase must not start a transaction");
        @(posedge clk); #1;
        slave_PSEL    = 1'b1;
        slave_PENABLE = 1'b0;
        slave_PADDR   = 32'h1A10_0000;
        req_cycles    = 0;
        repeat (4) begin
            @(negedge clk);
            if (data_req_o || slave_PREADY) req_cycles++;
        end
        checkOutput("setup_only_no_req", req_cycles, 0);
        @(posedge clk); #1;
        apbRelease();

        $display("[TB] read, immediate grant");
        applyStimulus(32'h1A10_0004, 32'h0, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 32'hDEADBEEF, 1'b0);

        $display("[TB] write, grant after 3 wait cycles");
        applyStimulus(32'h1A10_0010, 32'h1234_5678, 1'b1, 3, 0, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0, 1'b0);

        $display("[TB] read with error response");
        applyStimulus(32'h1A10_0020, 32'h0, 1'b0, 1, 2, 32'h55AA_55AA, 1'b1, 1'b0, 32'h55AA_55AA, 1'b1);

        $display("[TB] read with PSEL dropped mid-transaction");
        applyStimulus(32'h1A10_0030, 32'h0, 1'b0, 0, 1, 32'h0F0F_1234, 1'b0, 1'b1, 32'h0F0F_1234, 1'b0);

        $display("[TB] reset while waiting for r_valid");
        apbSetupAccess(32'h1A10_0008, 32'h0, 1'b0);
        @(posedge clk); #1;
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checkResetState();
        apbRelease();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'hBADB_AD00;
        @(posedge clk); #1;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = 32'h0;
        req_cycles = 0;
        repeat (3) begin
            @(negedge clk);
            if (data_req_o || slave_PREADY) req_cycles++;
        end
        checkOutput("stale_rvalid_ignored", req_cycles, 0);
        checkOutput("stale_rvalid_prdata", slave_PRDATA, 32'd0);
        applyStimulus(32'h1A10_000C, 32'h0, 1'b0, 0, 0, 32'h0BAD_F00D, 1'b0, 1'b0, 32'h0BAD_F00D, 1'b0);

`ifdef APB_2_LINT_GNT_TIMEOUT_EN
        $display("[TB] grant timeout after 4 cycles");
        apbSetupAccess(32'h1A10_0040, 32'h0, 1'b0);
        exp_q.push_back({32'h0, 1'b1});
        req_cycles = 0;
        seen_ready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (data_req_o) req_cycles++;
            if (slave_PREADY) begin
                seen_ready = 1'b1;
                break;
            end
        end
        checkOutput("timeout_req_cycles", req_cycles, 4);
        checkOutput("timeout_pready", {31'd0, seen_ready}, 32'd1);
        @(posedge clk); #1;
        apbRelease();
`else
        $display("[TB] no grant: request must stay asserted");
        apbSetupAccess(32'h1A10_0040, 32'h0, 1'b0);
        exp_q.push_back({32'h600D_CAFE, 1'b0});
        req_cycles = 0;
        repeat (12) begin
            @(negedge clk);
            if (data_req_o) req_cycles++;
        end
        checkOutput("no_timeout_req_held", req_cycles, 11);
        data_gnt_i = 1'b1;
        @(posedge clk); #1;
        data_gnt_i     = 1'b0;
        data_r_valid_i = 1'b1;
        data_r_rdata_i = 32'h600D_CAFE;
        @(posedge clk); #1;
        data_r_valid_i = 1'b0;
        data_r_rdata_i = 32'h0;
        @(negedge clk);
        checkOutput("late_gnt_pready", {31'd0, slave_PREADY}, 32'd1);
        @(posedge clk); #1;
        apbRelease();
`endif

        repeat (3) @(posedge clk);
        checkOutput("scoreboard_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
